// File: rtl/fetch_unit.sv
// Byte-wide instruction prefetcher: a three-state memory read handshake feeding a small FIFO.
// Optional macro FETCH_PERF_EN adds a 16-bit count of consumed bytes on port fetch_count.
module fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic              mem_ready,
    input  logic [7:0]        mem_read_value,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              instr_valid,
    output logic [7:0]        instr_byte,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_mem_address;
    logic                r_discard;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_fifo_byte [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_fifo_pc   [FIFO_DEPTH];

    logic                w_has_free;
    logic                w_complete;
    logic                w_push;
    logic                w_pop;
    logic                w_start;

    // Only IDLE can start a request, so nothing is in flight when the free-slot test is made.
    assign w_has_free = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_complete = (r_state == ST_READ) && mem_ready;
    assign w_push     = w_complete && !r_discard && !jump_valid;
    assign w_pop      = instr_valid && instr_ready && !jump_valid;
    assign w_start    = (r_state == ST_IDLE) && (w_state_next == ST_READ);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_has_free && !jump_valid) w_state_next = ST_READ;
            ST_READ:    if (mem_ready)                 w_state_next = ST_RELEASE;
            ST_RELEASE: if (!mem_ready)                w_state_next = ST_IDLE;
            default:                                   w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= '0;
            r_mem_address <= '0;
            r_discard     <= 1'b0;
        end else begin
            if (jump_valid) begin
                r_fetch_pc <= jump_target;
            end else if (w_complete && !r_discard) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
            end

            // The address is latched at request start so a redirect cannot disturb a live handshake.
            if (w_start) begin
                r_mem_address <= r_fetch_pc;
            end

            if ((r_state == ST_RELEASE) && !mem_ready) begin
                r_discard <= 1'b0;
            end else if (jump_valid && (r_state != ST_IDLE)) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || jump_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the occupancy counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_byte[r_wr_ptr] <= mem_read_value;
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign mem_read    = (r_state == ST_READ);
    assign mem_address = r_mem_address;
    assign instr_valid = (r_count != '0);
    assign instr_byte  = instr_valid ? r_fifo_byte[r_rd_ptr] : 8'h00;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr] : '0;

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_pop) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stream model of delivered (byte, pc) pairs plus directed scenarios.
module tb_fetch_unit;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk            = 1'b0;
    logic              reset          = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_ready      = 1'b0;
    logic [7:0]        mem_read_value;
    logic              jump_valid     = 1'b0;
    logic [ADDR_W-1:0] jump_target    = '0;
    logic              instr_valid;
    logic [7:0]        instr_byte;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready    = 1'b0;
`ifdef FETCH_PERF_EN
    logic [15:0]       fetch_count;
`endif

    fetch_unit #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_ready      (mem_ready),
        .mem_read_value (mem_read_value),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .instr_valid    (instr_valid),
        .instr_byte     (instr_byte),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] pc;
    } pop_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory: contents fixed at start, optional wait states before ready.
    logic [7:0] mem_model [256];
    assign mem_read_value = mem_model[mem_address];

    int fixed_lat = 0;
    bit rand_lat  = 1'b0;
    int lat_cnt   = 0;

    always @(posedge clk) begin
        #1;
        if (mem_read) begin
            if (lat_cnt == 0) begin
                mem_ready = 1'b1;
            end else begin
                lat_cnt--;
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
            lat_cnt   = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end
    end

    // Reference model: consumed bytes form a consecutive address run starting at 0 after
    // reset or at the target after a redirect, each carrying the memory byte at its address.
    bit          mon_en      = 1'b0;
    logic [7:0]  exp_pc      = '0;
    bit          exp_empty   = 1'b0;
    bit          exp_reset   = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [7:0]  prev_addr   = '0;
    int unsigned pop_total   = 0;
    int unsigned hs_count    = 0;
    logic [7:0]  last_hs_addr = '0;
    pop_t        pop_q [$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_reset) begin
                check("reset_mem_read", mem_read, 0);
                check("reset_mem_address", mem_address, 0);
                check("reset_instr_byte", instr_byte, 0);
                check("reset_instr_pc", instr_pc, 0);
            end
            if (exp_empty) check("flush_empty", instr_valid, 0);
            if (prev_stall) begin
                check("hold_mem_read", mem_read, 1);
                check("hold_mem_address", mem_address, prev_addr);
            end
            if (instr_valid) check("head_byte", instr_byte, mem_model[instr_pc]);
`ifdef FETCH_PERF_EN
            check("fetch_count", fetch_count, pop_total[15:0]);
`endif
            exp_empty  = 1'b0;
            exp_reset  = 1'b0;
            prev_stall = 1'b0;
            if (reset) begin
                exp_pc    = '0;
                pop_total = 0;
                exp_empty = 1'b1;
                exp_reset = 1'b1;
            end else begin
                if (mem_read && !mem_ready) begin
                    prev_stall = 1'b1;
                    prev_addr  = mem_address;
                end
                if (mem_read && mem_ready) begin
                    hs_count++;
                    last_hs_addr = mem_address;
                end
                if (jump_valid) begin
                    exp_pc    = jump_target;
                    exp_empty = 1'b1;
                end else if (instr_valid && instr_ready) begin
                    pop_t p;
                    check("pop_pc", instr_pc, exp_pc);
                    p.b  = instr_byte;
                    p.pc = instr_pc;
                    pop_q.push_back(p);
                    exp_pc = exp_pc + 8'd1;
                    pop_total++;
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        jump_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic wait_pops(input int target, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (pop_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic wait_read(input logic [7:0] addr, input bit want_equal, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (mem_read && ((mem_address == addr) == want_equal)) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   mark;
        int   hs_base;
        bit   ok;
        logic [7:0] lit_pc [3];

        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem_model[i] = 8'(10 + i);

        // Reset state and first request timing.
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_byte", instr_byte, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_mem_address", mem_address, 0);
        instr_ready = 1'b1;
        mark  = pop_q.size();
        reset = 1'b0;
        @(negedge clk);
        check("first_read_not_yet", mem_read, 0);
        @(posedge clk);
        #1;
        check("first_read", mem_read, 1);

        // Straight-line fetch of bytes 10..13.
        wait_pops(mark + 4, "seq_wait");
        if (pop_q.size() >= mark + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("seq_byte", pop_q[mark + k].b, 10 + k);
                check("seq_pc", pop_q[mark + k].pc, k);
            end
        end

        // Consumer stalled: FIFO fills with exactly four requests, then one pop frees one slot.
        instr_ready = 1'b0;
        fixed_lat   = 0;
        do_reset();
        hs_base = hs_count;
        repeat (30) @(posedge clk);
        #1;
        check("full_handshakes", hs_count - hs_base, 4);
        check("full_no_read", mem_read, 0);
        check("full_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, 0);
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("refill_handshakes", hs_count - hs_base, 5);
        check("refill_addr", last_hs_addr, 4);
        check("refill_no_read", mem_read, 0);
        check("refill_head_pc", instr_pc, 1);

        // Redirect while the read of address 2 is in flight.
        fixed_lat   = 3;
        instr_ready = 1'b1;
        do_reset();
        wait_read(8'h02, 1'b1, "jmp_wait_addr2");
        jump_valid  = 1'b1;
        jump_target = 8'h40;
        mark        = pop_q.size();
        @(posedge clk);
        #1;
        jump_valid = 1'b0;
        check("jmp_inflight_read", mem_read, 1);
        check("jmp_inflight_addr", mem_address, 8'h02);
        wait_read(8'h02, 1'b0, "jmp_wait_next_read");
        check("jmp_next_addr", mem_address, 8'h40);
        wait_pops(mark + 1, "jmp_wait_pop");
        if (pop_q.size() >= mark + 1) begin
            check("jmp_first_pc", pop_q[mark].pc, 8'h40);
            check("jmp_first_byte", pop_q[mark].b, mem_model[8'h40]);
        end

        // Address wrap after a redirect to the last byte.
        fixed_lat   = 0;
        jump_valid  = 1'b1;
        jump_target = 8'hFF;
        mark        = pop_q.size();
        @(posedge clk);
        #1;
        jump_valid = 1'b0;
        lit_pc[0] = 8'hFF;
        lit_pc[1] = 8'h00;
        lit_pc[2] = 8'h01;
        wait_pops(mark + 3, "wrap_wait");
        if (pop_q.size() >= mark + 3) begin
            for (int k = 0; k < 3; k++) begin
                check("wrap_pc", pop_q[mark + k].pc, lit_pc[k]);
                check("wrap_byte", pop_q[mark + k].b, mem_model[lit_pc[k]]);
            end
        end

        // Reset during an active read.
        instr_ready = 1'b0;
        fixed_lat   = 2;
        do_reset();
        wait_read(8'h01, 1'b1, "rstrd_wait");
        check("rstrd_pre_valid", instr_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstrd_mem_read", mem_read, 0);
        check("rstrd_instr_valid", instr_valid, 0);
        reset   = 1'b0;
        hs_base = hs_count;
        ok      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (hs_count > hs_base) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstrd_restart_seen", ok, 1);
        check("rstrd_restart_addr", last_hs_addr, 0);

`ifdef FETCH_PERF_EN
        // Performance counter: five pops, then cleared by reset.
        fixed_lat   = 0;
        instr_ready = 1'b0;
        do_reset();
        check("perf_reset", fetch_count, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (pop_total >= 5) break;
        end
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("perf_five", fetch_count, 5);
        do_reset();
        check("perf_cleared", fetch_count, 0);
`endif

        // Randomized traffic: variable latency, bursty consumer, redirects and rare resets.
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int bias;
            @(posedge clk);
            #1;
            bias        = ((c / 150) % 2 == 0) ? 3 : 1;
            instr_ready = ($urandom_range(0, 3) < bias);
            jump_valid  = ($urandom_range(0, 39) == 0);
            jump_target = 8'($urandom);
            reset       = ($urandom_range(0, 599) == 0);
        end
        @(posedge clk);
        #1;
        jump_valid  = 1'b0;
        reset       = 1'b0;
        instr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
